// File: rtl/spike_detector.sv
// Threshold-crossing spike detector for one membrane-potential register.
// Emits a one-cycle spike, holds the potential at rest through a refractory window, and reports spike count and ISI.
module spike_detector #(
    parameter int                    W      = 21,
    parameter logic signed [W-1:0]   V_TH   = 21'sd15360,
    parameter int                    REFRAC = 8,
    parameter int                    CNT_W  = 16
) (
    input  logic                clk,
    input  logic                set,
    input  logic signed [W-1:0] v,
    input  logic                v_valid,
    input  logic                count_clr,
    output logic                spike,
    output logic                v_reset,
    output logic                refractory,
    output logic [CNT_W-1:0]    spike_count,
    output logic [CNT_W-1:0]    isi,
    output logic                isi_valid
);

    typedef enum logic [1:0] {
        ARMED,
        FIRE,
        REFRACT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [7:0]       RCNT_LOAD = 8'(REFRAC - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       rcnt;
    logic [CNT_W-1:0] isi_cnt;
    logic             has_prev;

    logic             spike_d;
    logic             v_reset_d;
    logic             refractory_d;
    logic             isi_valid_d;
    logic [CNT_W-1:0] isi_cnt_inc;
    logic [CNT_W-1:0] count_inc;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ARMED:   if (v_valid && (v >= V_TH)) state_next = FIRE;
            FIRE:    state_next = REFRACT;
            REFRACT: if (rcnt == 8'd0) state_next = ARMED;
            default: state_next = ARMED;
        endcase

        // Outputs are decoded from the next state and registered below, so
        // spike rises in the cycle right after the qualifying sample.
        spike_d      = (state_next == FIRE);
        v_reset_d    = (state_next != ARMED);
        refractory_d = (state_next == REFRACT);
        isi_valid_d  = spike_d && has_prev;

        isi_cnt_inc  = (isi_cnt == CNT_MAX) ? isi_cnt : isi_cnt + CNT_W'(1);
        count_inc    = (spike_count == CNT_MAX) ? spike_count : spike_count + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (set) begin
            state       <= ARMED;
            rcnt        <= 8'd0;
            isi_cnt     <= '0;
            has_prev    <= 1'b0;
            spike       <= 1'b0;
            v_reset     <= 1'b0;
            refractory  <= 1'b0;
            isi_valid   <= 1'b0;
            spike_count <= '0;
            isi         <= '0;
        end else begin
            state      <= state_next;
            spike      <= spike_d;
            v_reset    <= v_reset_d;
            refractory <= refractory_d;
            isi_valid  <= isi_valid_d;

            if (state == FIRE)
                rcnt <= RCNT_LOAD;
            else if (state == REFRACT && rcnt != 8'd0)
                rcnt <= rcnt - 8'd1;

            // Distance is measured spike-cycle to spike-cycle, hence the +1.
            if (spike_d) begin
                isi_cnt  <= '0;
                has_prev <= 1'b1;
                if (has_prev) isi <= isi_cnt_inc;
            end else begin
                isi_cnt <= isi_cnt_inc;
            end

            // A clear coinciding with a spike keeps that spike.
            if (state == FIRE)
                spike_count <= count_clr ? CNT_W'(1) : count_inc;
            else if (count_clr)
                spike_count <= '0;
        end
    end

endmodule

// File: tb/tb_spike_detector.sv
// Directed bench for spike_detector: expected spikes go into a scoreboard queue
// and a negedge monitor pops and compares them whenever the DUT spikes.
module tb_spike_detector;

    localparam int W     = 21;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                set, v_valid, count_clr;
    logic signed [W-1:0] v;
    logic                spike, v_reset, refractory, isi_valid;
    logic [CNT_W-1:0]    spike_count, isi;

    logic                s_set, s_valid, s_clr;
    logic signed [W-1:0] s_v;
    logic                s_spike, s_v_reset, s_refr, s_isi_valid;
    logic [3:0]          s_count, s_isi;

    spike_detector dut (
        .clk(clk), .set(set), .v(v), .v_valid(v_valid), .count_clr(count_clr),
        .spike(spike), .v_reset(v_reset), .refractory(refractory),
        .spike_count(spike_count), .isi(isi), .isi_valid(isi_valid)
    );

    // Short counters and a one-cycle refractory window for saturation and boundary cases.
    spike_detector #(.REFRAC(1), .CNT_W(4)) u_small (
        .clk(clk), .set(s_set), .v(s_v), .v_valid(s_valid), .count_clr(s_clr),
        .spike(s_spike), .v_reset(s_v_reset), .refractory(s_refr),
        .spike_count(s_count), .isi(s_isi), .isi_valid(s_isi_valid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int               cyc;
        logic             iv;
        logic [CNT_W-1:0] isi;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_spike(input int at, input logic iv, input logic [CNT_W-1:0] isi_e);
        exp_t e;
        e.cyc = at;
        e.iv  = iv;
        e.isi = isi_e;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (spike === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious spike", spike, 0);
            end else begin
                e = sb.pop_front();
                check("spike cycle", cyc, e.cyc);
                check("isi_valid at spike", isi_valid, e.iv);
                check("isi at spike", isi, e.isi);
            end
        end else begin
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("expected spike present", spike, 1);
            end
            if (isi_valid === 1'b1) check("isi_valid without spike", isi_valid, 0);
        end
    end

    initial begin
        set = 1'b1; v = -21'sd35840; v_valid = 1'b1; count_clr = 1'b0;
        s_set = 1'b1; s_v = -21'sd35840; s_valid = 1'b0; s_clr = 1'b0;

        // Reset state and quiet input patterns
        step(2);
        set = 1'b0;
        check("reset spike", spike, 0);
        check("reset v_reset", v_reset, 0);
        check("reset refractory", refractory, 0);
        check("reset isi_valid", isi_valid, 0);
        check("reset spike_count", spike_count, 0);
        check("reset isi", isi, 0);
        step(6);
        v = {1'b1, 20'd0};
        step(4);
        v_valid = 1'b0; v = 21'sd20000;
        step(4);
        v_valid = 1'b1; v = -21'sd35840;
        step(1);
        check("quiet spike_count", spike_count, 0);
        check("quiet v_reset", v_reset, 0);

        // Just below, then exactly at threshold
        v = 21'sd15359;
        step(1);
        v = 21'sd15360;
        expect_spike(cyc + 1, 1'b0, 16'd0);
        step(1);
        v = -21'sd35840;
        for (int k = 0; k < 10; k++) begin
            check("v_reset window", v_reset, 32'(k < 9));
            check("refractory window", refractory, 32'(k >= 1 && k < 9));
            step(1);
        end
        check("count after first spike", spike_count, 1);

        // Held level: spikes every REFRAC+2 cycles
        set = 1'b1;
        step(1);
        set = 1'b0;
        v = 21'sd20000;
        expect_spike(cyc + 1,  1'b0, 16'd0);
        expect_spike(cyc + 11, 1'b1, 16'd10);
        expect_spike(cyc + 21, 1'b1, 16'd10);
        expect_spike(cyc + 31, 1'b1, 16'd10);
        step(2);
        check("count after spike 1", spike_count, 1);
        step(10);
        check("count after spike 2", spike_count, 2);
        step(10);
        check("count after spike 3", spike_count, 3);
        check("isi held", isi, 10);

        // Clear coinciding with a spike, then a clear alone
        step(9);
        count_clr = 1'b1; v = -21'sd35840;
        step(1);
        count_clr = 1'b0;
        check("clear with fire", spike_count, 1);
        step(5);
        count_clr = 1'b1;
        step(1);
        count_clr = 1'b0;
        check("clear alone", spike_count, 0);

        // Long gap saturates isi
        step(70000);
        v = 21'sd20000;
        expect_spike(cyc + 1, 1'b1, 16'hFFFF);
        step(1);
        v = -21'sd35840;

        // Reset in the third refractory cycle aborts the window
        step(3);
        check("in refractory before abort", refractory, 1);
        set = 1'b1;
        step(1);
        set = 1'b0;
        check("abort v_reset", v_reset, 0);
        check("abort refractory", refractory, 0);
        check("abort spike_count", spike_count, 0);
        check("abort isi", isi, 0);
        v = 21'sd20000;
        expect_spike(cyc + 1, 1'b0, 16'd0);
        step(1);
        v = -21'sd35840;
        check("re-armed spike", spike, 1);
        step(12);

        // One-cycle refractory window and narrow counter saturation
        s_set = 1'b0; s_valid = 1'b1; s_v = 21'sd20000;
        step(1);
        check("small spike", s_spike, 1);
        check("small fire refractory", s_refr, 0);
        check("small fire v_reset", s_v_reset, 1);
        step(1);
        check("small refract spike", s_spike, 0);
        check("small refract refractory", s_refr, 1);
        check("small refract v_reset", s_v_reset, 1);
        step(1);
        check("small armed refractory", s_refr, 0);
        check("small armed v_reset", s_v_reset, 0);
        step(1);
        check("small second spike", s_spike, 1);
        check("small isi_valid", s_isi_valid, 1);
        check("small isi", s_isi, 3);
        step(60);
        check("small count saturated", s_count, 15);
        s_v = -21'sd35840;
        step(40);
        s_v = 21'sd20000;
        step(1);
        check("small gap spike", s_spike, 1);
        check("small gap isi_valid", s_isi_valid, 1);
        check("small isi saturated", s_isi, 15);
        step(1);
        check("small count stays saturated", s_count, 15);
        s_v = -21'sd35840;
        step(4);

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
